mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arb_prio.sv | 47 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, grant encoding, debug view
// and the saturating counter helper.
package mem_arb_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int CNT_W         = 16;
  localparam int STREAK_DBG_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } gnt_t;

  // Observation bundle for checkers and waveform debug.
  typedef struct packed {
    state_t                  state;
    gnt_t                    gnt;
    logic [STREAK_DBG_W-1:0] d_streak;
  } dbg_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the single-port memory and the arbiter.
// slave = arbiter side, master = environment side (requesters + memory).
//
// Handshake: a requester raises x_req with stable operands and holds them until
// x_ready pulses for one cycle; it drops x_req at the edge ending that cycle.
// The memory sees m_read/m_write held stable until it pulses m_ack once.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ready;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;

  logic                 m_read;
  logic                 m_write;
  logic [WORD_SIZE-1:0] m_addr;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 m_ack;

  logic [15:0]          i_wait_cnt;
  logic [15:0]          d_wait_cnt;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output m_read, m_write, m_addr, m_wdata,
    input  m_rdata, m_ack,
    output i_wait_cnt, d_wait_cnt
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  m_read, m_write, m_addr, m_wdata,
    output m_rdata, m_ack,
    input  i_wait_cnt, d_wait_cnt
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection between the instruction and data ports, with a D-streak
// counter that lets a waiting instruction fetch in after MAX_D_STREAK D grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arb_en,
  input  logic                    i_req,
  input  logic                    d_req,
  output gnt_t                    gnt,
  output logic [STREAK_DBG_W-1:0] streak_dbg
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] d_streak;
  logic          streak_full;

  assign streak_full = (d_streak == SW'(MAX_D_STREAK));
  assign streak_dbg  = STREAK_DBG_W'(d_streak);

  // D normally wins; a waiting I takes over once the streak has saturated.
  always_comb begin
    gnt = GNT_NONE;
    if (arb_en) begin
      if (d_req && !(i_req && streak_full)) begin
        gnt = GNT_D;
      end else if (i_req) begin
        gnt = GNT_I;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_streak <= '0;
    end else if (gnt == GNT_I) begin
      d_streak <= '0;
    end else if (gnt == GNT_D && i_req && !streak_full) begin
      d_streak <= d_streak + SW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory.
// Optional stall counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output dbg_t         dbg
);

  state_t                  state;
  gnt_t                    gnt;
  logic                    arb_en;
  logic [STREAK_DBG_W-1:0] streak_dbg;

  logic                 m_read_q;
  logic                 m_write_q;
  logic [WORD_SIZE-1:0] m_addr_q;
  logic [WORD_SIZE-1:0] m_wdata_q;
  logic [WORD_SIZE-1:0] i_rdata_q;
  logic [WORD_SIZE-1:0] d_rdata_q;
  logic                 i_ready_q;
  logic                 d_ready_q;

  // Arbitration happens only from IDLE, so DONE never re-grants.
  assign arb_en = (state == IDLE);

  mem_arb_prio #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .arb_en     (arb_en),
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .gnt        (gnt),
    .streak_dbg (streak_dbg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt == GNT_D) begin
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            m_read_q  <= !bus.d_we;
            m_write_q <= bus.d_we;
            state     <= BUSY_D;
          end else if (gnt == GNT_I) begin
            m_addr_q  <= bus.i_addr;
            m_read_q  <= 1'b1;
            m_write_q <= 1'b0;
            state     <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (bus.m_ack) begin
            m_read_q  <= 1'b0;
            i_rdata_q <= bus.m_rdata;
            i_ready_q <= 1'b1;
            state     <= DONE_I;
          end
        end
        BUSY_D: begin
          if (bus.m_ack) begin
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            // Only loads update d_rdata; stores leave the last load visible.
            if (m_read_q) begin
              d_rdata_q <= bus.m_rdata;
            end
            d_ready_q <= 1'b1;
            state     <= DONE_D;
          end
        end
        DONE_I: begin
          i_ready_q <= 1'b0;
          state     <= IDLE;
        end
        DONE_D: begin
          d_ready_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_read  = m_read_q;
  assign bus.m_write = m_write_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] i_wait_q;
  logic [CNT_W-1:0] d_wait_q;
  logic             i_served;
  logic             d_served;

  // A port stalls whenever it is requesting but its own access is not in flight.
  assign i_served = (state == BUSY_I) || (state == DONE_I);
  assign d_served = (state == BUSY_D) || (state == DONE_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      i_wait_q <= '0;
      d_wait_q <= '0;
    end else begin
      if (bus.i_req && !i_served) begin
        i_wait_q <= sat_inc(i_wait_q);
      end
      if (bus.d_req && !d_served) begin
        d_wait_q <= sat_inc(d_wait_q);
      end
    end
  end

  assign bus.i_wait_cnt = i_wait_q;
  assign bus.d_wait_cnt = d_wait_q;
`else
  assign bus.i_wait_cnt = '0;
  assign bus.d_wait_cnt = '0;
`endif

  assign dbg.state    = state;
  assign dbg.gnt      = gnt;
  assign dbg.d_streak = streak_dbg;

endmodule
